// File: rtl/chain_score_max.sv
// chain_score_max: reduces a stream of (f[j] + gap score) candidates per anchor to the best f[i], its predecessor and a candidate count.
// Optional early stop after MAX_SKIP consecutive non-improving candidates: define CHAIN_MAX_SKIP_EN.
module chain_score_max #(
  parameter int IDX_W    = 16,
  parameter int MAX_SKIP = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_score,
  input  logic [31:0]      s_fj,
  input  logic [IDX_W-1:0] s_j_idx,
  input  logic [31:0]      s_wi,
  input  logic             s_empty,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_f,
  output logic [IDX_W-1:0] m_pred,
  output logic [IDX_W-1:0] m_cnt
);

  localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(MAX_SKIP);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        best_q, best_d;
  logic [IDX_W-1:0]   pred_q, pred_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;

  logic [32:0]        sum;
  logic [31:0]        cand;
  logic               beat;
  logic               skip_hit;
  logic [31:0]        base_best;
  logic [IDX_W-1:0]   base_pred;
  logic [IDX_W-1:0]   base_cnt;
  logic [SKIP_W-1:0]  base_skip;

  // 33-bit sum clamped back into the signed 32-bit range
  assign sum  = {s_fj[31], s_fj} + {s_score[31], s_score};
  assign cand = (sum[32] != sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];

  assign beat    = s_valid && s_ready;
  assign s_ready = (state_q != OUT);
  assign m_valid = (state_q == OUT);
  assign m_f     = best_q;
  assign m_pred  = pred_q;
  assign m_cnt   = cnt_q;

  always_comb begin
    base_best = best_q;
    base_pred = pred_q;
    base_cnt  = cnt_q;
    base_skip = skip_q;
    if (state_q == IDLE) begin
      base_best = s_wi;
      base_pred = '1;
      base_cnt  = '0;
      base_skip = '0;
    end
  end

`ifdef CHAIN_MAX_SKIP_EN
  assign skip_hit = (base_skip == SKIP_LIM);
`else
  assign skip_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          best_d  = base_best;
          pred_d  = base_pred;
          cnt_d   = base_cnt;
          skip_d  = base_skip;
          state_d = s_last ? OUT : ACCUM;
          if (!s_empty && !skip_hit) begin
            if (base_cnt != '1) cnt_d = base_cnt + 1'b1;
            // strict compare: ties keep the earlier predecessor
            if ($signed(cand) > $signed(base_best)) begin
              best_d = cand;
              pred_d = s_j_idx;
              skip_d = '0;
            end else if (base_skip != SKIP_LIM) begin
              skip_d = base_skip + 1'b1;
            end
          end
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      best_q  <= '0;
      pred_q  <= '1;
      cnt_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_chain_score_max.sv
// Self-checking bench for chain_score_max: directed cases plus random anchors against a behavioural reference model.
// Expected results follow CHAIN_MAX_SKIP_EN when the bench is built with it.
module tb_chain_score_max;

  localparam int TB_MAX_SKIP = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 0;
  logic        reset;
  logic        s_valid, s_ready, s_empty, s_last;
  logic [31:0] s_score, s_fj, s_wi;
  logic [15:0] s_j_idx;
  logic        m_valid, m_ready;
  logic [31:0] m_f;
  logic [15:0] m_pred, m_cnt;

  chain_score_max #(.IDX_W(16), .MAX_SKIP(TB_MAX_SKIP)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score), .s_fj(s_fj),
    .s_j_idx(s_j_idx), .s_wi(s_wi), .s_empty(s_empty), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_f(m_f), .m_pred(m_pred), .m_cnt(m_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_wi;
  logic [31:0] b_fj [64];
  logic [31:0] b_sc [64];
  logic [15:0] b_j  [64];
  bit          b_emp[64];
  int          nb;
  logic [31:0] got_f;
  logic [15:0] got_pred, got_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: best of wi and every counted candidate, first one wins on ties
  task automatic model(output logic [31:0] ef, output logic [15:0] ep, output logic [15:0] ec);
    longint best, c;
    int cnt, skip;
    best = longint'($signed(a_wi));
    ep = 16'hFFFF;
    cnt = 0;
    skip = 0;
    for (int i = 0; i < nb; i++) begin
      if (b_emp[i]) continue;
`ifdef CHAIN_MAX_SKIP_EN
      if (skip == TB_MAX_SKIP) continue;
`endif
      c = longint'($signed(b_fj[i])) + longint'($signed(b_sc[i]));
      if (c > MAXV) c = MAXV;
      if (c < MINV) c = MINV;
      if (cnt < 65535) cnt++;
      if (c > best) begin
        best = c;
        ep = b_j[i];
        skip = 0;
      end else begin
        skip++;
      end
    end
    ef = best[31:0];
    ec = cnt[15:0];
  endtask

  task automatic set_beat(input int i, input logic [31:0] fj, input logic [31:0] sc,
                          input logic [15:0] j, input bit emp);
    b_fj[i] = fj; b_sc[i] = sc; b_j[i] = j; b_emp[i] = emp;
  endtask

  task automatic run_anchor(input string tag, input int stall);
    logic [31:0] ef;
    logic [15:0] ep, ec;
    model(ef, ep, ec);
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 0;
        m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk({tag, ":gap_mv"}, 64'(m_valid), 64'd0);
      end
      s_valid = 1;
      s_wi    = (i == 0) ? a_wi : $urandom;
      s_fj    = b_fj[i];
      s_score = b_sc[i];
      s_j_idx = b_j[i];
      s_empty = b_emp[i];
      s_last  = (i == nb - 1);
      m_ready = 1'($urandom_range(0, 1));
      chk({tag, ":rdy"}, 64'(s_ready), 64'd1);
      @(posedge clk); #1;
    end
    s_valid = 0; s_last = 0; m_ready = 0;
    chk({tag, ":mv"}, 64'(m_valid), 64'd1);
    got_f = m_f; got_pred = m_pred; got_cnt = m_cnt;
    chk({tag, ":f"}, 64'(m_f), 64'(ef));
    chk({tag, ":pred"}, 64'(m_pred), 64'(ep));
    chk({tag, ":cnt"}, 64'(m_cnt), 64'(ec));
    for (int k = 0; k < stall; k++) begin
      s_valid = 1; s_wi = $urandom; s_fj = $urandom; s_score = $urandom;
      s_empty = 0; s_last = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, ":hold_mv"}, 64'(m_valid), 64'd1);
      chk({tag, ":hold_rdy"}, 64'(s_ready), 64'd0);
      chk({tag, ":hold_out"}, {m_f, m_pred, m_cnt}, {got_f, got_pred, got_cnt});
    end
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0; s_valid = 0; s_last = 0;
    chk({tag, ":done_mv"}, 64'(m_valid), 64'd0);
    chk({tag, ":done_rdy"}, 64'(s_ready), 64'd1);
  endtask

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 200)) - 32'd100;
  endfunction

  initial begin
    reset = 1; s_valid = 0; s_empty = 0; s_last = 0; m_ready = 0;
    s_score = 0; s_fj = 0; s_wi = 0; s_j_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mv", 64'(m_valid), 64'd0);
    chk("rst_out", {m_f, m_pred, m_cnt}, {32'd0, 16'hFFFF, 16'd0});
    reset = 0;
    @(posedge clk); #1;
    chk("rst_rdy", 64'(s_ready), 64'd1);

    a_wi = 10; nb = 3;
    set_beat(0, 5, 3, 7, 0); set_beat(1, 20, -32'sd2, 8, 0); set_beat(2, 15, 3, 9, 0);
    run_anchor("basic", 0);
    chk("basic_const", {got_f, got_pred, got_cnt}, {32'd18, 16'd8, 16'd3});

    a_wi = 15; nb = 1;
    set_beat(0, $urandom, $urandom, 16'h1234, 1);
    run_anchor("empty", 1);
    chk("empty_const", {got_f, got_pred, got_cnt}, {32'd15, 16'hFFFF, 16'd0});

    a_wi = 0; nb = 2;
    set_beat(0, 32'h7FFF_FFF0, 32'h100, 3, 0); set_beat(1, 32'h7FFF_FFFF, 0, 4, 0);
    run_anchor("sat", 0);
    chk("sat_const", {got_f, got_pred, got_cnt}, {32'h7FFF_FFFF, 16'd3, 16'd2});

    a_wi = 32'h8000_0005; nb = 2;
    set_beat(0, 32'h8000_0000, 32'hFFFF_FF00, 5, 0); set_beat(1, 32'h8000_0000, 32'h1, 6, 0);
    run_anchor("negsat", 2);

    a_wi = 7; nb = 2;
    set_beat(0, 1, 2, 11, 0); set_beat(1, 100, 1, 12, 0);
    run_anchor("stall", 5);
    a_wi = 3; nb = 1;
    set_beat(0, 2, 2, 13, 0);
    run_anchor("after_stall", 0);
    chk("after_stall_const", {got_f, got_pred, got_cnt}, {32'd4, 16'd13, 16'd1});

    a_wi = 10; nb = 3;
    set_beat(0, 5, 0, 1, 0); set_beat(1, 4, 0, 2, 0); set_beat(2, 50, 0, 3, 0);
    run_anchor("skip", 0);
`ifdef CHAIN_MAX_SKIP_EN
    chk("skip_const", {got_f, got_pred, got_cnt}, {32'd10, 16'hFFFF, 16'd2});
`else
    chk("skip_const", {got_f, got_pred, got_cnt}, {32'd50, 16'd3, 16'd3});
`endif

    // two beats of a four-beat anchor, then reset
    s_valid = 1; s_wi = 32'd1000; s_fj = 32'd5000; s_score = 0; s_j_idx = 16'd77;
    s_empty = 0; s_last = 0;
    @(posedge clk); #1;
    s_wi = $urandom; s_fj = 32'd6000; s_j_idx = 16'd78;
    @(posedge clk); #1;
    s_valid = 0;
    reset = 1;
    #1;
    chk("mid_rst_mv", 64'(m_valid), 64'd0);
    chk("mid_rst_out", {m_f, m_pred, m_cnt}, {32'd0, 16'hFFFF, 16'd0});
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("post_rst_mv", 64'(m_valid), 64'd0);
    chk("post_rst_rdy", 64'(s_ready), 64'd1);
    a_wi = 1; nb = 2;
    set_beat(0, 2, 0, 20, 0); set_beat(1, 1, 0, 21, 0);
    run_anchor("post_rst", 0);
    chk("post_rst_const", {got_f, got_pred, got_cnt}, {32'd2, 16'd20, 16'd2});

    for (int a = 0; a < 30; a++) begin
      a_wi = rnd_val();
      nb = $urandom_range(1, 24);
      for (int i = 0; i < nb; i++)
        set_beat(i, rnd_val(), rnd_val(), 16'($urandom), ($urandom_range(0, 5) == 0));
      run_anchor("rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chain_score_max.md
CHAIN_SCORE_MAX -- requirements
Module: chain_score_max

Interface
REQ-001 SHALL have parameter IDX_W, default 16: width of predecessor index and candidate count.
REQ-002 SHALL have parameter MAX_SKIP, default 25: consecutive non-improving candidates tolerated before early stop (used only under CHAIN_MAX_SKIP_EN).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  upstream candidate beat valid.
REQ-006 SHALL have port s_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port s_score  input  32  signed gap score of pair (i,j) from the score stage.
REQ-008 SHALL have port s_fj  input  32  signed chain score f[j] of predecessor j.
REQ-009 SHALL have port s_j_idx  input  IDX_W  index of predecessor j.
REQ-010 SHALL have port s_wi  input  32  signed seed weight of anchor i, sampled on the first beat of an anchor.
REQ-011 SHALL have port s_empty  input  1  beat carries no candidate (anchor with no predecessors); score/fj/j_idx ignored.
REQ-012 SHALL have port s_last  input  1  final beat of the current anchor.
REQ-013 SHALL have port m_valid  output  1  result for anchor i valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts result.
REQ-015 SHALL have port m_f  output  32  signed best chain score f[i].
REQ-016 SHALL have port m_pred  output  IDX_W  best predecessor index; all-ones = none.
REQ-017 SHALL have port m_cnt  output  IDX_W  candidates evaluated for anchor i, saturating at all-ones.

Function
REQ-018 SHALL implement states IDLE, ACCUM, OUT; a beat transfers when s_valid and s_ready are both high.
REQ-019 SHALL drive s_ready high in IDLE and ACCUM, low in OUT.
REQ-020 SHALL, on a beat accepted in IDLE, load best=s_wi, pred=all-ones, cnt=0, skip=0, then evaluate that beat's candidate in the same cycle; the next state is ACCUM, or OUT if s_last.
REQ-021 SHALL form candidate c = s_fj + s_score as a 33-bit signed sum saturated to the 32-bit signed range.
REQ-022 SHALL replace best with c and pred with s_j_idx only when c > best (strict); ties keep the earlier predecessor.
REQ-023 SHALL increment cnt for every evaluated non-empty candidate, saturating; s_empty beats neither evaluate nor count.
REQ-024 SHALL move to OUT on the accepted s_last beat and assert m_valid the following cycle, with m_f/m_pred/m_cnt including that beat (1-cycle latency).
REQ-025 SHALL hold m_valid and all m_* outputs stable in OUT until m_ready, then return to IDLE in the next cycle; m_ready while m_valid is low SHALL be ignored.
REQ-026 SHALL ignore s_wi on all beats except the first of an anchor.
REQ-027 SHALL NOT start a new anchor in the cycle the result is handed off, because s_ready is low in OUT; the minimum spacing is one idle-ready cycle per anchor.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-anchor, go to IDLE immediately and discard partial state.
REQ-029 SHALL reset m_valid=0, m_f=0, m_pred=all-ones, m_cnt=0, internal best/cnt/skip=0; s_ready SHALL be high one cycle after reset deasserts.

Configuration
REQ-030 SHALL, with CHAIN_MAX_SKIP_EN defined, keep a skip counter that clears on improvement, increments on each non-improving evaluated candidate, and, once it equals MAX_SKIP, accepts but ignores the remaining candidates of the anchor (no best/pred/cnt change) until s_last.
REQ-031 SHALL, without CHAIN_MAX_SKIP_EN, evaluate every candidate; the skip counter and MAX_SKIP SHALL have no effect on behaviour.

Verification
REQ-032 SHALL cover: wi=10, candidates (fj,score)=(5,3),(20,-2),(15,3) with j=7,8,9 and last on the third -> m_f=18, m_pred=8, m_cnt=3, m_valid one cycle after the last beat.
REQ-033 SHALL cover: single s_empty+s_last beat with wi=15 -> m_f=15, m_pred=all-ones, m_cnt=0.
REQ-034 SHALL cover: fj=0x7FFFFFF0 and score=0x100 -> c saturates to 0x7FFFFFFF; tie with an equal later candidate keeps the first pred.
REQ-035 SHALL cover: m_ready held low 5 cycles -> outputs stable and s_ready low throughout, then IDLE and a new anchor accepted.
REQ-036 SHALL cover: with CHAIN_MAX_SKIP_EN and MAX_SKIP=2, wi=10 and candidates 5,4,50 -> m_f=10, m_cnt=2; without the macro -> m_f=50, m_cnt=3.
REQ-037 SHALL cover: reset pulsed after 2 of 4 beats -> m_valid stays 0, and the next anchor's result is independent of the discarded beats.
